// File: rtl/bus_arbiter_if.sv
// Two-master / one-slave bus bundle seen by the arbiter.
// The slave modport is the arbiter side; the master modport is the environment side.
interface bus_arbiter_if;
    logic        i_m0_cs;
    logic        i_m0_we;
    logic [15:0] i_m0_addr;
    logic [15:0] i_m0_dat;
    logic [15:0] o_m0_dat;
    logic        o_m0_ack;

    logic        i_m1_cs;
    logic        i_m1_we;
    logic [15:0] i_m1_addr;
    logic [15:0] i_m1_dat;
    logic [15:0] o_m1_dat;
    logic        o_m1_ack;

    logic        o_s_cs;
    logic        o_s_we;
    logic [15:0] o_s_addr;
    logic [15:0] o_s_dat;
    logic [15:0] i_s_dat;
    logic        i_s_ack;

    logic        o_grant;
    logic        o_timeout;
    logic        i_timeout_clr;

    modport slave (
        input  i_m0_cs, i_m0_we, i_m0_addr, i_m0_dat,
        output o_m0_dat, o_m0_ack,
        input  i_m1_cs, i_m1_we, i_m1_addr, i_m1_dat,
        output o_m1_dat, o_m1_ack,
        output o_s_cs, o_s_we, o_s_addr, o_s_dat,
        input  i_s_dat, i_s_ack,
        output o_grant, o_timeout,
        input  i_timeout_clr
    );

    modport master (
        output i_m0_cs, i_m0_we, i_m0_addr, i_m0_dat,
        input  o_m0_dat, o_m0_ack,
        output i_m1_cs, i_m1_we, i_m1_addr, i_m1_dat,
        input  o_m1_dat, o_m1_ack,
        input  o_s_cs, o_s_we, o_s_addr, o_s_dat,
        output i_s_dat, i_s_ack,
        input  o_grant, o_timeout,
        output i_timeout_clr
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one slave between two masters, with a parked grant
// and a wait-cycle watchdog that forces an all-ones ack on a hung slave.
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    bus_arbiter_if.slave  bus
);
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 8;

    typedef enum logic {GRANT0 = 1'b0, GRANT1 = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic            timeout_q;

    logic            own_cs, own_we, other_cs;
    logic [DW-1:0]   own_addr, own_dat;
    logic            tmo_hit, served;

    // State register, wait counter and sticky timeout flag
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= GRANT0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (tmo_hit)
                timeout_q <= 1'b1;
            else if (bus.i_timeout_clr)
                timeout_q <= 1'b0;
        end
    end

    // Owner mux, acks, next grant and next wait count
    always_comb begin
        state_d       = state_q;
        wait_d        = '0;
        bus.o_s_cs    = 1'b0;
        bus.o_s_we    = 1'b0;
        bus.o_s_addr  = '0;
        bus.o_s_dat   = '0;
        bus.o_m0_ack  = 1'b0;
        bus.o_m0_dat  = '0;
        bus.o_m1_ack  = 1'b0;
        bus.o_m1_dat  = '0;

        if (state_q == GRANT1) begin
            own_cs   = bus.i_m1_cs;
            own_we   = bus.i_m1_we;
            own_addr = bus.i_m1_addr;
            own_dat  = bus.i_m1_dat;
            other_cs = bus.i_m0_cs;
        end else begin
            own_cs   = bus.i_m0_cs;
            own_we   = bus.i_m0_we;
            own_addr = bus.i_m0_addr;
            own_dat  = bus.i_m0_dat;
            other_cs = bus.i_m1_cs;
        end

        bus.o_s_cs = own_cs;
        bus.o_s_we = own_cs & own_we;
        if (own_cs) begin
            bus.o_s_addr = own_addr;
            bus.o_s_dat  = own_dat;
        end

        // A real ack in the same cycle as the limit wins over the forced one
        tmo_hit = (wait_q == CW'(TIMEOUT)) & own_cs & ~bus.i_s_ack;
        served  = own_cs & (bus.i_s_ack | tmo_hit);

        if (state_q == GRANT1) begin
            bus.o_m1_ack = served;
            if (served) bus.o_m1_dat = bus.i_s_ack ? bus.i_s_dat : {DW{1'b1}};
        end else begin
            bus.o_m0_ack = served;
            if (served) bus.o_m0_dat = bus.i_s_ack ? bus.i_s_dat : {DW{1'b1}};
        end

        if (other_cs && (served || !own_cs))
            state_d = (state_q == GRANT1) ? GRANT0 : GRANT1;
        else if (own_cs && !served)
            wait_d = CW'(wait_q + CW'(1));
    end

    assign bus.o_grant   = (state_q == GRANT1);
    assign bus.o_timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations, then a
// randomized run compared every cycle against a transaction-level model.
module tb_bus_arbiter;
    localparam int unsigned TMO = 4;

    logic i_clk = 1'b0;
    logic i_reset;
    int   n_err = 0;
    int   n_chk = 0;

    bus_arbiter_if bus ();

    bus_arbiter #(.TIMEOUT(TMO)) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        bus.i_m0_cs = 0; bus.i_m0_we = 0; bus.i_m0_addr = '0; bus.i_m0_dat = '0;
        bus.i_m1_cs = 0; bus.i_m1_we = 0; bus.i_m1_addr = '0; bus.i_m1_dat = '0;
        bus.i_s_ack = 0; bus.i_s_dat = '0; bus.i_timeout_clr = 0;
    endtask

    // Transaction-level model: who owns the bus, how long the slave has stalled, sticky flag
    bit m_valid = 0;
    int m_owner = 0;
    int m_stall = 0;
    bit m_flag  = 0;

    always @(negedge i_clk) begin
        bit          cs[2];
        bit          we[2];
        logic [15:0] ad[2];
        logic [15:0] wd[2];
        bit          reqd, forced, done;
        int          oth;
        logic [15:0] eack, edat;

        cs[0] = bus.i_m0_cs; we[0] = bus.i_m0_we; ad[0] = bus.i_m0_addr; wd[0] = bus.i_m0_dat;
        cs[1] = bus.i_m1_cs; we[1] = bus.i_m1_we; ad[1] = bus.i_m1_addr; wd[1] = bus.i_m1_dat;
        reqd   = cs[m_owner];
        forced = reqd && !bus.i_s_ack && (m_stall == int'(TMO));
        done   = reqd && (bus.i_s_ack || forced);
        oth    = 1 - m_owner;

        if (m_valid) begin
            chk("mdl_grant",   16'(bus.o_grant),   16'(m_owner));
            chk("mdl_timeout", 16'(bus.o_timeout), 16'(m_flag));
            chk("mdl_s_cs",    16'(bus.o_s_cs),    16'(reqd));
            chk("mdl_s_we",    16'(bus.o_s_we),    16'(reqd && we[m_owner]));
            chk("mdl_s_addr",  bus.o_s_addr,       reqd ? ad[m_owner] : 16'h0);
            chk("mdl_s_dat",   bus.o_s_dat,        reqd ? wd[m_owner] : 16'h0);
            for (int x = 0; x < 2; x++) begin
                eack = 16'(done && (x == m_owner));
                edat = (eack != 0) ? (bus.i_s_ack ? bus.i_s_dat : 16'hFFFF) : 16'h0;
                chk(x == 0 ? "mdl_m0_ack" : "mdl_m1_ack",
                    x == 0 ? 16'(bus.o_m0_ack) : 16'(bus.o_m1_ack), eack);
                chk(x == 0 ? "mdl_m0_dat" : "mdl_m1_dat",
                    x == 0 ? bus.o_m0_dat : bus.o_m1_dat, edat);
            end
        end

        if (i_reset) begin
            m_valid = 1; m_owner = 0; m_stall = 0; m_flag = 0;
        end else if (m_valid) begin
            if (forced)                   m_flag = 1;
            else if (bus.i_timeout_clr)   m_flag = 0;
            if (cs[oth] && (done || !reqd)) begin
                m_owner = oth;
                m_stall = 0;
            end else if (reqd && !done) begin
                m_stall = m_stall + 1;
            end else begin
                m_stall = 0;
            end
        end
    end

    initial begin
        int a0, a1;
        logic [15:0] exp_o;

        idle();
        i_reset = 1;
        step(); step();
        i_reset = 0;
        @(negedge i_clk);
        chk("rst_grant",   16'(bus.o_grant),   16'd0);
        chk("rst_timeout", 16'(bus.o_timeout), 16'd0);
        chk("rst_s_cs",    16'(bus.o_s_cs),    16'd0);

        // m0 read, slave acks the next cycle
        step(); bus.i_m0_cs = 1; bus.i_m0_addr = 16'h0010;
        @(negedge i_clk);
        chk("rd_s_cs",   16'(bus.o_s_cs),   16'd1);
        chk("rd_s_addr", bus.o_s_addr,      16'h0010);
        chk("rd_ack0",   16'(bus.o_m0_ack), 16'd0);
        step(); bus.i_s_ack = 1; bus.i_s_dat = 16'hBEEF;
        @(negedge i_clk);
        chk("rd_ack1",   16'(bus.o_m0_ack), 16'd1);
        chk("rd_dat",    bus.o_m0_dat,      16'hBEEF);
        chk("rd_grant",  16'(bus.o_grant),  16'd0);
        step(); idle();
        @(negedge i_clk);
        chk("rd_park", 16'(bus.o_grant), 16'd0);

        // m1 write while m0 idle
        step(); bus.i_m1_cs = 1; bus.i_m1_we = 1; bus.i_m1_addr = 16'h8000; bus.i_m1_dat = 16'h1234;
        @(negedge i_clk);
        chk("wr_grant0", 16'(bus.o_grant), 16'd0);
        chk("wr_s_cs0",  16'(bus.o_s_cs),  16'd0);
        step();
        @(negedge i_clk);
        chk("wr_grant1", 16'(bus.o_grant), 16'd1);
        chk("wr_s_we",   16'(bus.o_s_we),  16'd1);
        chk("wr_s_addr", bus.o_s_addr,     16'h8000);
        chk("wr_s_dat",  bus.o_s_dat,      16'h1234);
        step(); bus.i_s_ack = 1;
        @(negedge i_clk);
        chk("wr_ack1", 16'(bus.o_m1_ack), 16'd1);
        chk("wr_ack0", 16'(bus.o_m0_ack), 16'd0);
        step(); idle(); bus.i_s_ack = 1;
        @(negedge i_clk);
        chk("wr_park",      16'(bus.o_grant),  16'd1);
        chk("stray_ack_m1", 16'(bus.o_m1_ack), 16'd0);
        step(); idle(); bus.i_m1_cs = 1; bus.i_m1_addr = 16'h8002;
        @(negedge i_clk);
        chk("park_s_cs",   16'(bus.o_s_cs), 16'd1);
        chk("park_s_addr", bus.o_s_addr,    16'h8002);
        step(); idle();

        // both masters hold cs, slave acks every second cycle
        step(); bus.i_m0_cs = 1; bus.i_m0_addr = 16'h0100; bus.i_m1_cs = 1; bus.i_m1_addr = 16'h0200;
        a0 = 0; a1 = 0;
        for (int k = 0; k < 8; k++) begin
            bus.i_s_ack = k[0];
            @(negedge i_clk);
            if (bus.o_m0_ack) a0++;
            if (bus.o_m1_ack) a1++;
            if (k[0]) begin
                exp_o = (k % 4 == 1) ? 16'd1 : 16'd0;
                chk("rr_grant", 16'(bus.o_grant),  exp_o);
                chk("rr_ack1",  16'(bus.o_m1_ack), exp_o);
            end
            step();
        end
        chk("rr_cnt0", 16'(a0), 16'd2);
        chk("rr_cnt1", 16'(a1), 16'd2);
        idle();

        // hung slave: forced ack on the fifth cycle of o_s_cs
        i_reset = 1;
        step();
        i_reset = 0; bus.i_m0_cs = 1; bus.i_m0_addr = 16'h0040;
        for (int c = 1; c <= 5; c++) begin
            @(negedge i_clk);
            chk("tmo_s_cs", 16'(bus.o_s_cs), 16'd1);
            chk("tmo_ack",  16'(bus.o_m0_ack), (c == 5) ? 16'd1 : 16'd0);
            if (c == 5) chk("tmo_dat", bus.o_m0_dat, 16'hFFFF);
            step();
        end
        bus.i_m0_cs = 0;
        @(negedge i_clk);
        chk("tmo_flag", 16'(bus.o_timeout), 16'd1);
        step(); bus.i_timeout_clr = 1;
        @(negedge i_clk);
        chk("tmo_flag_hold", 16'(bus.o_timeout), 16'd1);
        step(); bus.i_timeout_clr = 0;
        @(negedge i_clk);
        chk("tmo_clr", 16'(bus.o_timeout), 16'd0);

        // real ack on the limit cycle beats the forced ack
        step(); bus.i_m0_cs = 1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge i_clk);
            chk("lim_ack0", 16'(bus.o_m0_ack), 16'd0);
            step();
        end
        bus.i_s_ack = 1; bus.i_s_dat = 16'h5A5A;
        @(negedge i_clk);
        chk("lim_ack", 16'(bus.o_m0_ack), 16'd1);
        chk("lim_dat", bus.o_m0_dat,      16'h5A5A);
        step(); idle();
        @(negedge i_clk);
        chk("lim_noflag", 16'(bus.o_timeout), 16'd0);

        // reset in the middle of an m1 transfer
        step(); bus.i_m1_cs = 1; bus.i_m1_addr = 16'h9000;
        step();
        @(negedge i_clk);
        chk("mid_grant1", 16'(bus.o_grant), 16'd1);
        step(); i_reset = 1;
        step(); i_reset = 0;
        @(negedge i_clk);
        chk("mid_grant0",  16'(bus.o_grant),   16'd0);
        chk("mid_no_ack",  16'(bus.o_m1_ack),  16'd0);
        chk("mid_s_cs",    16'(bus.o_s_cs),    16'd0);
        chk("mid_timeout", 16'(bus.o_timeout), 16'd0);
        step(); idle();

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step();
            bus.i_m0_cs       = ($urandom_range(0, 99) < 60);
            bus.i_m1_cs       = ($urandom_range(0, 99) < 55);
            bus.i_m0_we       = 1'($urandom);
            bus.i_m1_we       = 1'($urandom);
            bus.i_m0_addr     = 16'($urandom);
            bus.i_m1_addr     = 16'($urandom);
            bus.i_m0_dat      = 16'($urandom);
            bus.i_m1_dat      = 16'($urandom);
            bus.i_s_dat       = 16'($urandom);
            bus.i_s_ack       = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 30 : 8));
            bus.i_timeout_clr = ($urandom_range(0, 99) < 5);
            i_reset           = ($urandom_range(0, 199) < 2);
        end
        step(); idle(); i_reset = 0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning slave wait cycles before a forced ack (legal 1..255).
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port i_reset  input  1  reset is synchronous and active-high.
REQ-004 SHALL have ports i_m0_cs, i_m0_we  input  1 each  master 0 (CPU) request and write enable.
REQ-005 SHALL have ports i_m0_addr, i_m0_dat  input  16 each  master 0 address and write data.
REQ-006 SHALL have ports o_m0_dat  output  16, and o_m0_ack  output  1  master 0 read data and ack.
REQ-007 SHALL have i_m1_cs, i_m1_we (1), i_m1_addr, i_m1_dat (16), o_m1_dat (16), o_m1_ack (1), with the same meanings for master 1 (DMA/debug).
REQ-008 SHALL have ports o_s_cs, o_s_we  output  1 each  shared slave request and write enable.
REQ-009 SHALL have ports o_s_addr, o_s_dat  output  16 each  shared slave address and write data.
REQ-010 SHALL have ports i_s_dat  input  16, and i_s_ack  input  1  slave read data and ack.
REQ-011 SHALL have port o_grant  output  1  current owner (0 = master 0, 1 = master 1).
REQ-012 SHALL have port o_timeout  output  1  sticky flag: a forced ack has occurred.
REQ-013 SHALL have port i_timeout_clr  input  1  clears o_timeout.

Function
REQ-014 SHALL hold two states, GRANT0 and GRANT1; o_grant equals the state (registered); no idle state, so the grant parks on the last owner.
REQ-015 Slave side SHALL be a combinational mux of the owner: o_s_cs = owner cs; o_s_we = owner cs & owner we; o_s_addr/o_s_dat = owner addr/dat when owner cs is high, else 0.
REQ-016 o_mX_ack SHALL be (grant==X) & i_mX_cs & (i_s_ack | tmo_hit), combinational, same cycle as slave ack; non-owner ack is always 0.
REQ-017 o_mX_dat SHALL be i_s_dat when master X gets ack from i_s_ack, 16'hFFFF when acked by tmo_hit, else 0.
REQ-018 Transaction end is the cycle the owner gets ack; requests held across cycles without ack SHALL never lose the grant.
REQ-019 At a transaction-end edge: other master cs high -> switch grant (round-robin); otherwise keep grant.
REQ-020 When the owner cs is low and the other master cs is high, the grant SHALL switch at the next edge; the other master sees o_s_cs one cycle after raising cs.
REQ-021 Parked owner raising cs SHALL reach o_s_cs in the same cycle (zero added latency).
REQ-022 Both cs low: grant unchanged.
REQ-023 8-bit wait counter SHALL increment each cycle with o_s_cs=1 and i_s_ack=0, and SHALL clear on any ack, grant change, or o_s_cs=0.
REQ-024 tmo_hit SHALL be (counter == TIMEOUT) & o_s_cs & ~i_s_ack; it acts as ack for REQ-016..REQ-019, and o_s_cs remains asserted in that cycle.
REQ-025 o_timeout SHALL set on the edge after tmo_hit; if i_timeout_clr and tmo_hit coincide, set wins.
REQ-026 Real i_s_ack in the same cycle as the counter reaching TIMEOUT SHALL take precedence (real data, no flag).
REQ-027 i_s_ack while o_s_cs is low SHALL be ignored (no master ack, no state change).

Reset
REQ-028 i_reset SHALL force GRANT0, counter 0, o_timeout 0 at the next edge, overriding all other events.
REQ-029 Outputs SHALL follow REQ-015..REQ-017 from the reset state, so o_s_cs mirrors i_m0_cs immediately; an in-flight master-1 transfer is abandoned without ack.

Verification
REQ-030 Reset, m0 read addr 0x0010, slave acks next cycle with 0xBEEF -> o_s_cs same cycle, o_m0_ack=1, o_m0_dat=0xBEEF, o_grant stays 0.
REQ-031 m0 and m1 cs held continuously, slave acks every 2nd cycle -> grants alternate 0,1,0,1; each master acked once per two transactions, never starved.
REQ-032 m1 write 0x1234 to 0x8000 while m0 idle -> o_grant=1 one cycle later, o_s_we=1, o_s_addr=0x8000, o_s_dat=0x1234; grant parks on 1 after ack.
REQ-033 TIMEOUT=4, m0 request, slave never acks -> o_m0_ack=1 with o_m0_dat=0xFFFF on the 5th cycle of o_s_cs, o_timeout=1 next cycle; i_timeout_clr clears it.
REQ-034 Reset asserted mid m1 transfer (grant=1, awaiting ack) -> next cycle o_grant=0, no o_m1_ack, counter 0, o_timeout 0.
